// File: rtl/inst_rom_if.sv
// Fetch and load bus between the CPU/boot loader (master) and inst_rom (slave).
interface inst_rom_if;
  logic [31:0] address;
  logic [31:0] inst;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  modport master (
    output address,
    output load_en,
    output load_addr,
    output load_data,
    input  inst
  );

  modport slave (
    input  address,
    input  load_en,
    input  load_addr,
    input  load_data,
    output inst
  );
endinterface

// File: rtl/inst_rom.sv
// inst_rom: word-addressed instruction memory with a reset-loaded default
// program, a combinational fetch read and a one-word-per-cycle load port.
module inst_rom #(
  parameter int DEPTH = 256
) (
  input  logic      clk,
  input  logic      rst,
  inst_rom_if.slave bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  function automatic logic [31:0] default_word(input int unsigned idx);
    logic [31:0] w;
    case (idx)
      32'd0:   w = 32'h0C20_0005;
      32'd1:   w = 32'h0C40_0003;
      32'd2:   w = 32'h2461_1000;
      32'd3:   w = 32'h0860_0000;
      32'd4:   w = 32'h0C80_0003;
      32'd5:   w = 32'h5880_0000;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];
  logic [31:0] inst_s;

  // Fetch read: full-width compare so out-of-range addresses never alias.
  always_comb begin
    inst_s = 32'h0000_0000;
    if (bus.address < DEPTH_W) begin
      inst_s = mem_q[bus.address[AW-1:0]];
    end else begin
      inst_s = 32'h0000_0000;
    end
  end

  assign bus.inst = inst_s;

  // Next memory image: reset reloads every word and overrides any load.
  always_comb begin
    mem_d = mem_q;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = default_word(i);
      end
    end else if (bus.load_en && (bus.load_addr < DEPTH_W)) begin
      mem_d[bus.load_addr[AW-1:0]] = bus.load_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage update on the rising edge.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_inst_rom.sv
// Bench for inst_rom: directed plan plus random traffic, checked through a
// scoreboard queue against an array model of the memory.
module tb_inst_rom;
  localparam int DEPTH = 256;

  logic clk;
  logic rst;
  inst_rom_if bus ();

  inst_rom #(.DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  string       name_q [$];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [31:0] image_word(input int idx);
    logic [31:0] img [6];
    img[0] = 32'h0C20_0005;
    img[1] = 32'h0C40_0003;
    img[2] = 32'h2461_1000;
    img[3] = 32'h0860_0000;
    img[4] = 32'h0C80_0003;
    img[5] = 32'h5880_0000;
    if (idx < 6) return img[idx];
    return 32'h0000_0000;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'(DEPTH)) return model[a[7:0]];
    return 32'h0000_0000;
  endfunction

  // One cycle: drive just after the edge, record the expected pre-edge read,
  // then advance the model to what the coming edge will store.
  task automatic cycle(input logic r, input logic le, input logic [31:0] la,
                       input logic [31:0] ld, input logic [31:0] a,
                       input bit chk, input string nm);
    @(posedge clk);
    #1;
    rst           = r;
    bus.load_en   = le;
    bus.load_addr = la;
    bus.load_data = ld;
    bus.address   = a;
    if (chk) begin
      exp_q.push_back(model_read(a));
      name_q.push_back(nm);
    end
    if (r) begin
      for (int i = 0; i < DEPTH; i++) model[i] = image_word(i);
    end else if (le && (la < 32'(DEPTH))) begin
      model[la[7:0]] = ld;
    end
  endtask

  task automatic rd(input logic [31:0] a, input string nm);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, a, 1'b1, nm);
  endtask

  // Monitor: the read is combinational, so every negedge presents an output.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [31:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (bus.inst !== e) begin
        bad++;
        $display("FAIL %s addr=%h got=%h want=%h", n, bus.address, bus.inst, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, la, ld;
    logic        r, le;
    rst = 1'b0; bus.load_en = 1'b0; bus.load_addr = 32'h0;
    bus.load_data = 32'h0; bus.address = 32'h0;
    for (int i = 0; i < DEPTH; i++) model[i] = image_word(i);

    // Reset, then sweep the default program.
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "pre_reset");
    for (int i = 0; i < 8; i++) rd(32'(i), "reset_sweep");
    rd(32'(DEPTH), "oob_depth");
    rd(32'hFFFF_FFFF, "oob_max");

    // Read-during-write on word 2.
    cycle(1'b0, 1'b1, 32'd2, 32'hDEAD_BEEF, 32'd2, 1'b1, "rdw_before");
    rd(32'd2, "rdw_after");
    rd(32'd3, "rdw_neighbour");

    // Out-of-range load is ignored.
    cycle(1'b0, 1'b1, 32'(DEPTH + 1), 32'h1234_5678, 32'(DEPTH + 1), 1'b1, "oob_load_rd");
    for (int i = 0; i < DEPTH; i++) rd(32'(i), "oob_load_sweep");
    rd(32'(DEPTH + 1), "oob_load_rd2");

    // Reset beats load.
    cycle(1'b1, 1'b1, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, "rst_load_same");
    rd(32'd0, "rst_beats_load");
    rd(32'd2, "rst_restores_w2");

    // Loads then reset.
    cycle(1'b0, 1'b1, 32'd0, 32'h1111_1111, 32'd0, 1'b1, "ld0");
    cycle(1'b0, 1'b1, 32'd1, 32'h2222_2222, 32'd0, 1'b1, "ld1");
    cycle(1'b0, 1'b1, 32'd2, 32'h3333_3333, 32'd1, 1'b1, "ld2");
    cycle(1'b0, 1'b1, 32'd3, 32'h4444_4444, 32'd2, 1'b1, "ld3");
    for (int i = 0; i < 4; i++) rd(32'(i), "loaded");
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'd3, 1'b1, "reset_cycle");
    for (int i = 0; i < 4; i++) rd(32'(i), "reloaded");

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      r  = ($urandom_range(0, 39) == 0);
      le = $urandom_range(0, 1) == 1;
      la = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, DEPTH - 1));
      ld = $urandom();
      case ($urandom_range(0, 9))
        0:       a = 32'hFFFF_FFFF;
        1:       a = 32'(DEPTH + $urandom_range(0, 3));
        2:       a = la;
        default: a = 32'($urandom_range(0, DEPTH - 1));
      endcase
      cycle(r, le, la, ld, a, 1'b1, "random");
    end
    rd(32'd0, "final");

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
